// File: rtl/gpio_ctrl_if.sv
// gpio_ctrl_if: CPU-side register bus and interrupt line of gpio_ctrl.
interface gpio_ctrl_if;
    logic [2:0] addr;
    logic       wr_en;
    logic       rd_en;
    logic [7:0] wdata;
    logic [7:0] rdata;
    logic       rd_valid;
    logic       irq;

    modport master (
        output addr, wr_en, rd_en, wdata,
        input  rdata, rd_valid, irq
    );

    modport slave (
        input  addr, wr_en, rd_en, wdata,
        output rdata, rd_valid, irq
    );
endinterface

// File: rtl/gpio_ctrl.sv
// gpio_ctrl: switch/LED peripheral with 2-flop sync, per-bit debounce, rising-edge capture,
// masked level interrupt and register bus. Define GPIO_PWM_EN to add an 8-bit PWM LED dimmer.
module gpio_ctrl #(
    parameter int unsigned SW_WIDTH        = 4,
    parameter int unsigned LED_WIDTH       = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [SW_WIDTH-1:0]  switches,
    output logic [LED_WIDTH-1:0] LEDs,
    gpio_ctrl_if.slave           bus
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    localparam logic [2:0] ADDR_LED  = 3'd0;
    localparam logic [2:0] ADDR_SW   = 3'd1;
    localparam logic [2:0] ADDR_EDGE = 3'd2;
    localparam logic [2:0] ADDR_MASK = 3'd3;
`ifdef GPIO_PWM_EN
    localparam logic [2:0] ADDR_PWM  = 3'd4;
`endif

    logic [SW_WIDTH-1:0]  r_sync1;
    logic [SW_WIDTH-1:0]  r_sync2;
    logic [SW_WIDTH-1:0]  r_stable;
    logic [CNT_W-1:0]     r_cnt [SW_WIDTH];
    logic [SW_WIDTH-1:0]  r_edge;
    logic [SW_WIDTH-1:0]  r_mask;
    logic [LED_WIDTH-1:0] r_led;
    logic [LED_WIDTH-1:0] r_leds;
    logic [7:0]           r_rdata;
    logic                 r_rd_valid;
    logic                 r_irq;

    logic [SW_WIDTH-1:0]  w_stable_nxt;
    logic [CNT_W-1:0]     w_cnt_nxt [SW_WIDTH];
    logic [SW_WIDTH-1:0]  w_rise;
    logic [SW_WIDTH-1:0]  w_edge_clr;
    logic [SW_WIDTH-1:0]  w_edge_nxt;
    logic [SW_WIDTH-1:0]  w_mask_nxt;
    logic [LED_WIDTH-1:0] w_led_nxt;
    logic [LED_WIDTH-1:0] w_led_drv;
    logic [7:0]           w_rd_mux;
    logic                 w_wr_led;
    logic                 w_wr_edge;
    logic                 w_wr_mask;
    logic                 w_unused;

    assign w_unused = ^bus.wdata;

    // Per-bit debounce: stable follows sw_sync only after DEBOUNCE_CYCLES differing cycles
    always_comb begin
        w_stable_nxt = r_stable;
        for (int i = 0; i < int'(SW_WIDTH); i++) begin
            w_cnt_nxt[i] = '0;
            if (r_sync2[i] != r_stable[i]) begin
                if (r_cnt[i] == CNT_MAX) begin
                    w_stable_nxt[i] = r_sync2[i];
                end else begin
                    w_cnt_nxt[i] = r_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    assign w_wr_led  = bus.wr_en && (bus.addr == ADDR_LED);
    assign w_wr_edge = bus.wr_en && (bus.addr == ADDR_EDGE);
    assign w_wr_mask = bus.wr_en && (bus.addr == ADDR_MASK);

    // A new rising edge beats a simultaneous write-1-to-clear
    assign w_rise     = w_stable_nxt & ~r_stable;
    assign w_edge_clr = w_wr_edge ? bus.wdata[SW_WIDTH-1:0] : '0;
    assign w_edge_nxt = (r_edge & ~w_edge_clr) | w_rise;
    assign w_mask_nxt = w_wr_mask ? bus.wdata[SW_WIDTH-1:0] : r_mask;
    assign w_led_nxt  = w_wr_led ? bus.wdata[LED_WIDTH-1:0] : r_led;

`ifdef GPIO_PWM_EN
    logic [7:0] r_pwm_cnt;
    logic [7:0] r_duty;
    logic [7:0] w_pwm_cnt_nxt;
    logic [7:0] w_duty_nxt;
    logic       w_wr_duty;

    assign w_wr_duty     = bus.wr_en && (bus.addr == ADDR_PWM);
    assign w_pwm_cnt_nxt = r_pwm_cnt + 8'd1;
    assign w_duty_nxt    = w_wr_duty ? bus.wdata : r_duty;
    // LED drive is registered, so gate with the counter/duty values that land this edge
    assign w_led_drv     = w_led_nxt & {LED_WIDTH{w_pwm_cnt_nxt < w_duty_nxt}};

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_pwm_cnt <= 8'd0;
            r_duty    <= 8'hFF;
        end else begin
            r_pwm_cnt <= w_pwm_cnt_nxt;
            r_duty    <= w_duty_nxt;
        end
    end
`else
    assign w_led_drv = w_led_nxt;
`endif

    // Read mux sees pre-write register values
    always_comb begin
        w_rd_mux = '0;
        case (bus.addr)
            ADDR_LED:  w_rd_mux = 8'(r_led);
            ADDR_SW:   w_rd_mux = 8'(r_stable);
            ADDR_EDGE: w_rd_mux = 8'(r_edge);
            ADDR_MASK: w_rd_mux = 8'(r_mask);
`ifdef GPIO_PWM_EN
            ADDR_PWM:  w_rd_mux = r_duty;
`endif
            default:   w_rd_mux = '0;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_sync1    <= '0;
            r_sync2    <= '0;
            r_stable   <= '0;
            r_edge     <= '0;
            r_mask     <= '0;
            r_led      <= '0;
            r_leds     <= '0;
            r_rdata    <= '0;
            r_rd_valid <= 1'b0;
            r_irq      <= 1'b0;
            for (int i = 0; i < int'(SW_WIDTH); i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_sync1    <= switches;
            r_sync2    <= r_sync1;
            r_stable   <= w_stable_nxt;
            r_edge     <= w_edge_nxt;
            r_mask     <= w_mask_nxt;
            r_led      <= w_led_nxt;
            r_leds     <= w_led_drv;
            r_rd_valid <= bus.rd_en;
            r_irq      <= |(r_edge & r_mask);
            if (bus.rd_en) begin
                r_rdata <= w_rd_mux;
            end
            for (int i = 0; i < int'(SW_WIDTH); i++) begin
                r_cnt[i] <= w_cnt_nxt[i];
            end
        end
    end

    assign LEDs         = r_leds;
    assign bus.rdata    = r_rdata;
    assign bus.rd_valid = r_rd_valid;
    assign bus.irq      = r_irq;

endmodule

// File: doc/gpio_ctrl.md
Name: gpio_ctrl

Overview:
- Parametrised switch/LED peripheral for the system top level.
- Generalises the fixed 4-LED / 4-switch interface to configurable widths.
- Adds switch synchronisation and debounce, rising-edge capture, a masked interrupt, and a register read/write bus for the CPU.
- Sits between the board pins (`switches`, `LEDs`) and the processor data bus.

Parameters:
- SW_WIDTH, 4, number of switch inputs (1..8)
- LED_WIDTH, 4, number of LED outputs (1..8)
- DEBOUNCE_CYCLES, 16, consecutive stable cycles required before a switch change is accepted (>=2)

Ports:
- clock  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-high reset
- switches  in  SW_WIDTH  raw, asynchronous switch pins
- LEDs  out  LED_WIDTH  LED drive
- addr  in  3  register address
- wr_en  in  1  write strobe, one cycle
- rd_en  in  1  read strobe, one cycle
- wdata  in  8  write data
- rdata  out  8  read data, registered
- rd_valid  out  1  rdata valid, one-cycle pulse
- irq  out  1  level interrupt

Behaviour:
- Reset state: all outputs and all state elements are 0. LEDs=0, rdata=0, rd_valid=0, irq=0, stable=0, edge=0, mask=0.
- Synchroniser: 2-flop per switch bit, giving sw_sync. Latency from pin to sw_sync is 2 cycles.
- Debounce, per bit, each with its own counter of width clog2(DEBOUNCE_CYCLES):
  - If sw_sync == stable, the counter clears to 0.
  - Otherwise the counter increments.
  - When the counter reaches DEBOUNCE_CYCLES-1 while still differing, stable takes sw_sync and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES never changes stable.
- Edge capture: a 0->1 transition of stable[i] sets edge[i] on the same cycle stable updates. 1->0 transitions are not captured.
- Register map (addr):
  - 0 LED: RW. Bits [LED_WIDTH-1:0] are used; upper bits read 0.
  - 1 SW: RO. Returns the debounced stable value. Writes are ignored.
  - 2 EDGE: RW1C. Writing 1 to a bit clears it.
  - 3 MASK: RW, interrupt enable per switch bit.
  - 4 PWM: see Optional Feature.
  - 5-7: reads return 0, writes are ignored.
- Simultaneous events:
  - W1C clear and a new rising edge on the same bit in the same cycle: the set wins and the bit stays 1.
  - wr_en and rd_en in the same cycle to the same address: the read returns the pre-write value.
- Read timing: rd_en in cycle N gives rdata and rd_valid=1 in cycle N+1. When there is no read, rdata holds its last value.
- LED write: a write in cycle N appears on LEDs in cycle N+1.
- irq is registered: irq = |(edge & mask), one cycle after edge or mask change.
- Reset mid-debounce: the counters clear and stable returns to 0. An edge set by the post-reset debounce is captured normally.

Optional Feature:
- Macro: GPIO_PWM_EN.
- Defined:
  - An 8-bit free-running pwm_cnt and an 8-bit duty register at addr 4 (RW, reset value 8'hFF).
  - LEDs = led_reg & {LED_WIDTH{pwm_cnt < duty}}.
  - duty=0 gives LEDs permanently off. duty=255 gives LEDs on 255 of every 256 cycles.
  - pwm_cnt resets to 0.
- Undefined:
  - No counter and no duty register.
  - addr 4 reads 0 and writes are ignored.
  - LEDs = led_reg directly.

Test Plan:
- Release reset at 7 ns with switches=0 -> LEDs=0, irq=0; read addr 1 -> rdata=8'h00 one cycle after rd_en, rd_valid pulses once.
- Write addr 0 with 8'hA5, LED_WIDTH=4 -> LEDs=4'b0101 next cycle; read addr 0 -> 8'h05.
- switches=4'b0001 held for 2+DEBOUNCE_CYCLES+1 cycles -> addr 1 reads 8'h01, addr 2 reads 8'h01; toggle bit 0 with a pulse of DEBOUNCE_CYCLES-2 cycles -> stable and edge unchanged.
- Write MASK=8'h01 with edge[0]=1 -> irq=1 one cycle later; write addr 2 with 8'h01 -> irq=0; W1C in the same cycle as a new rising edge -> edge[0] stays 1.
- Assert reset mid-debounce (counter at DEBOUNCE_CYCLES/2) -> all registers and outputs 0 immediately, without waiting for a clock edge.
- With GPIO_PWM_EN defined: LED=4'hF, duty=8'd64 -> LEDs high for exactly 64 of 256 cycles; duty=0 -> LEDs constant 0. Without the macro: addr 4 reads 0 and LEDs stay 4'hF.
